tone_gen: RTL and testbench
===========================

# tone_gen

Multi-channel, parametrised square-wave tone generator with per-note duration, replacing the single fixed-period square wave source in the audio path. A sequencer loads notes through a valid/ready handshake. Each channel plays its note at a programmed half-period for a programmed number of timebase ticks, then goes silent and reports completion. Per-channel outputs and an OR-mixed output feed the speaker/PWM stage.

## Interface
- `CHANNELS`, default 2: number of independent tone channels (≥1).
- `HALF_W`, default 32: width of the half-period field, in clk cycles.
- `DUR_W`, default 16: width of the duration field, in ticks.
- `TICK_DIV`, default 48000: clk cycles per duration tick (≥2).
- `CH_W`, default `$clog2(CHANNELS)` (min 1): channel-select width.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `note_valid`  in  1: note request.
- `note_ready`  out  1: target channel can accept a note.
- `note_chan`  in  CH_W: target channel.
- `note_half_period`  in  HALF_W: half-period in cycles; 0 means rest.
- `note_duration`  in  DUR_W: note length in ticks.
- `note_stop`  in  CHANNELS: per-channel abort request.
- `sound`  out  CHANNELS: per-channel square wave.
- `sound_mix`  out  1: OR of all `sound` bits.
- `busy`  out  CHANNELS: channel is playing or resting.
- `done`  out  CHANNELS: one-cycle pulse at natural note end.

## Operation
- Reset values: `sound`=0, `sound_mix`=0, `busy`=0, `done`=0. All counters are 0. `note_ready`=0 while `rst` is high.
- Timebase: a single free-running tick counter counts 0..TICK_DIV-1 and wraps. `tick` pulses when the count equals TICK_DIV-1. The counter is not realigned on note accept.
- `note_ready` = !rst & !busy[note_chan] & !note_stop[note_chan]. This path is combinational.
- Accept occurs when `note_valid` & `note_ready`. `note_chan` ≥ CHANNELS is never ready.
- Each channel runs an FSM with states IDLE, PLAY, and REST.
  - IDLE→PLAY on accept with half_period≠0.
  - IDLE→REST on accept with half_period=0.
  - IDLE→IDLE on accept with duration=0: `done` pulses on the next cycle and there is no sound.
  - On entry to PLAY or REST: half-period counter=0, sound=0, remaining=duration.
- PLAY: the half-period counter increments each cycle. When it equals half_period-1, it wraps to 0 and `sound` toggles. half_period=1 toggles `sound` every cycle.
- REST: `sound` is held at 0.
- In PLAY or REST, `remaining` decrements on each `tick`. On the tick where remaining becomes 0:
  - the channel goes to IDLE,
  - `sound`←0,
  - `done`=1 for one cycle.
- `note_stop[i]` in PLAY or REST forces IDLE and `sound`←0 at the next edge, with no `done`. Stop has priority over tick end on the same cycle. Stop on an IDLE channel has no effect.
- Channels are fully independent. One accept per cycle is possible (single request port).
- Mid-note `rst` aborts all channels immediately with reset values. No `done` is produced.
- `sound_mix` is a registered OR of the next `sound` values, so it is cycle-aligned with `sound`.

## Timing
- `busy[i]`=1 from the edge after accept.
- First `sound` rise occurs half_period cycles after the accept edge. The period is 2·half_period cycles.
- Note length from accept to `done` is between (duration-1)·TICK_DIV+1 and duration·TICK_DIV cycles, depending on tick phase.
- `done` is asserted in the same cycle that `busy` falls. The channel is ready again in that cycle.
- Arithmetic is unsigned. Comparisons use the full HALF_W width, so there is no truncation. The counter never exceeds half_period-1.

## Configuration
- `TONE_GEN_LOOP_EN` defined: duration=0 enters PLAY or REST with no tick countdown. The channel then runs until `note_stop` or `rst`, and `done` never pulses for that note.
- Macro undefined: duration=0 produces an immediate `done` (next cycle) and the channel stays IDLE.

## Test plan
- Reset: hold `rst` for 3 cycles mid-note. Require `sound`, `busy`, `done`, `sound_mix`=0 and `note_ready`=0 during reset, and `note_ready`=1 in the first cycle after reset.
- TICK_DIV=10: chan0 with half_period=4, duration=2. Require `sound` to rise 4 cycles after accept and toggle every 4 cycles thereafter. Require `done` to pulse once, 11–20 cycles after accept. Require `sound`=0 afterward.
- Chan0 with half_period=1, duration=1. Require `sound` to toggle every cycle until the end, then drop to 0.
- Rest: half_period=0, duration=3. Require `sound` to remain 0 and `busy`=1 for 3 ticks, followed by a `done` pulse.
- Busy rejection and mix:
  - A second note to chan0 while it is busy sees `note_ready`=0 and is ignored (chan0 period unchanged).
  - Chan1 is accepted concurrently.
  - `sound_mix` equals sound[0]|sound[1] every cycle.
- Stop and loop:
  - `note_stop[0]` mid-note drops `sound` next cycle with no `done`.
  - With `TONE_GEN_LOOP_EN` defined, duration=0 plays for 1000+ cycles until stop.
  - Without the macro, duration=0 gives `done` on the next cycle.

Source files
------------

// File: rtl/tone_gen.sv
// Multi-channel square-wave tone generator with per-note duration and a shared tick timebase.
// Optional TONE_GEN_LOOP_EN: duration=0 plays until note_stop/rst instead of finishing immediately.
module tone_gen #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned HALF_W   = 32,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned TICK_DIV = 48000,
  parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [CH_W-1:0]     note_chan,
  input  logic [HALF_W-1:0]   note_half_period,
  input  logic [DUR_W-1:0]    note_duration,
  input  logic [CHANNELS-1:0] note_stop,
  output logic [CHANNELS-1:0] sound,
  output logic                sound_mix,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    REST = 2'd2
  } state_t;

  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic                ready_sel;
  logic [CHANNELS-1:0] sound_nxt;

  // Free-running timebase, never realigned to note accepts
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Out-of-range channel numbers match no channel and stay not-ready
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (note_chan == CH_W'(i)) begin
        ready_sel = !busy[i] && !note_stop[i];
      end
    end
    note_ready = !rst && ready_sel;
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    state_t            state;
    logic [HALF_W-1:0] half;
    logic [HALF_W-1:0] cnt;
    logic [DUR_W-1:0]  rem;
    logic              done_r;
    logic              accept;
    logic              wrap;
    logic              end_tick;

    assign accept   = note_valid && note_ready && (note_chan == CH_W'(g));
    assign wrap     = (cnt == half - HALF_W'(1));
    // rem==0 only occurs for looping notes, which never end on a tick
    assign end_tick = tick && (rem == DUR_W'(1));
    assign busy[g]  = (state != IDLE);
    assign done[g]  = done_r;

    always_comb begin
      sound_nxt[g] = 1'b0;
      if (!rst && state == PLAY && !note_stop[g] && !end_tick) begin
        sound_nxt[g] = wrap ? !sound[g] : sound[g];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        half   <= '0;
        cnt    <= '0;
        rem    <= '0;
        done_r <= 1'b0;
      end else begin
        done_r <= 1'b0;
        case (state)
          IDLE: begin
            if (accept) begin
              half <= note_half_period;
              cnt  <= '0;
              rem  <= note_duration;
`ifdef TONE_GEN_LOOP_EN
              state <= (note_half_period == '0) ? REST : PLAY;
`else
              if (note_duration == '0) begin
                done_r <= 1'b1;
              end else begin
                state <= (note_half_period == '0) ? REST : PLAY;
              end
`endif
            end
          end
          PLAY, REST: begin
            if (note_stop[g]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (end_tick) begin
              state  <= IDLE;
              cnt    <= '0;
              done_r <= 1'b1;
            end else begin
              if (tick && rem != '0) begin
                rem <= rem - DUR_W'(1);
              end
              if (state == PLAY) begin
                cnt <= wrap ? '0 : cnt + HALF_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Mix is built from next-sound values so it lines up with sound
  always_ff @(posedge clk) begin
    if (rst) begin
      sound     <= '0;
      sound_mix <= 1'b0;
    end else begin
      sound     <= sound_nxt;
      sound_mix <= |sound_nxt;
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen (TICK_DIV=10, two channels) with a per-cycle channel model.
module tb_tone_gen;

  localparam int TD = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        note_valid;
  logic        note_ready;
  logic [0:0]  note_chan;
  logic [31:0] note_half_period;
  logic [15:0] note_duration;
  logic [1:0]  note_stop;
  logic [1:0]  sound;
  logic        sound_mix;
  logic [1:0]  busy;
  logic [1:0]  done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit alive [2];
  bit loopm [2];
  int hpm   [2];
  int durm  [2];
  int start [2];
  int pend  [2];

  tone_gen #(
    .CHANNELS(2), .HALF_W(32), .DUR_W(16), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
    .note_chan(note_chan), .note_half_period(note_half_period),
    .note_duration(note_duration), .note_stop(note_stop), .sound(sound),
    .sound_mix(sound_mix), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] es;
    int k;
    for (int c = 0; c < 2; c++) begin
      k = cyc - start[c];
      if (done[c] === 1'b1) begin
        if (pend[c] == cyc) begin
          pend[c] = -1;
        end else if (alive[c] && !loopm[c]) begin
          check($sformatf("done_latency_ch%0d_k%0d", c, k),
                64'((k >= (durm[c] - 1) * TD + 1) && (k <= durm[c] * TD)), 64'd1);
          alive[c] = 1'b0;
        end else begin
          check($sformatf("spurious_done_ch%0d", c), 64'(done[c]), 64'd0);
        end
      end else if (pend[c] == cyc) begin
        check($sformatf("missing_done_ch%0d", c), 64'(done[c]), 64'd1);
        pend[c] = -1;
      end else if (alive[c] && !loopm[c] && k >= durm[c] * TD) begin
        check($sformatf("late_done_ch%0d_k%0d", c, k), 64'(done[c]), 64'd1);
        alive[c] = 1'b0;
      end
      es[c] = (alive[c] && hpm[c] != 0) ? 1'((k / hpm[c]) % 2) : 1'b0;
      check($sformatf("sound_ch%0d_k%0d", c, k), 64'(sound[c]), 64'(es[c]));
      check($sformatf("busy_ch%0d", c), 64'(busy[c]), 64'(alive[c]));
    end
    check("sound_mix", 64'(sound_mix), 64'(|es));
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input int c, input int h, input int d, input bit exp_r);
    note_chan = 1'(c);
    note_half_period = 32'(h);
    note_duration = 16'(d);
    note_valid = 1'b1;
    #1;
    check($sformatf("note_ready_ch%0d", c), 64'(note_ready), 64'(exp_r));
    @(negedge clk);
    note_valid = 1'b0;
    if (exp_r) begin
      start[c] = cyc;
      hpm[c] = h;
      durm[c] = d;
      loopm[c] = 1'b0;
      if (d == 0) begin
`ifdef TONE_GEN_LOOP_EN
        alive[c] = 1'b1;
        loopm[c] = 1'b1;
`else
        pend[c] = cyc;
`endif
      end else begin
        alive[c] = 1'b1;
      end
    end
    check_outputs();
  endtask

  task automatic do_stop(input int c);
    note_chan = 1'(c);
    note_stop = 2'(1 << c);
    #1;
    check("note_ready_stop", 64'(note_ready), 64'd0);
    @(negedge clk);
    alive[c] = 1'b0;
    loopm[c] = 1'b0;
    check_outputs();
    note_stop = 2'b00;
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((alive[0] || alive[1]) && n < max) begin
      step();
      n++;
    end
    check("idle_timeout", 64'(alive[0] | alive[1]), 64'd0);
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      alive[c] = 1'b0;
      loopm[c] = 1'b0;
      pend[c] = -1;
    end
    #1;
    check("note_ready_in_reset", 64'(note_ready), 64'd0);
    for (int i = 0; i < n; i++) begin
      step();
      check("note_ready_in_reset", 64'(note_ready), 64'd0);
      check("done_in_reset", 64'(done), 64'd0);
    end
    rst = 1'b0;
    note_chan = 1'b0;
    #1;
    check("note_ready_after_reset", 64'(note_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    note_valid = 1'b0;
    note_chan = 1'b0;
    note_half_period = '0;
    note_duration = '0;
    note_stop = 2'b00;
    for (int c = 0; c < 2; c++) begin
      alive[c] = 1'b0;
      loopm[c] = 1'b0;
      hpm[c] = 0;
      durm[c] = 0;
      start[c] = 0;
      pend[c] = -1;
    end
    @(negedge clk);
    reset_cycles(3);

    // Basic tone: half-period 4, two ticks
    send(0, 4, 2, 1'b1);
    run_idle(30);
    step();

    // Fastest tone
    send(0, 1, 1, 1'b1);
    run_idle(20);
    step();

    // Rest note
    send(0, 0, 3, 1'b1);
    run_idle(40);
    step();

    // Busy rejection plus concurrent second channel
    send(0, 3, 4, 1'b1);
    send(0, 7, 1, 1'b0);
    send(1, 5, 2, 1'b1);
    run_idle(50);
    step();

    // Stop mid-note: no done afterwards
    send(0, 4, 8, 1'b1);
    repeat (6) step();
    do_stop(0);
    repeat (5) step();

    // Reset mid-note on both channels
    send(0, 4, 5, 1'b1);
    send(1, 0, 5, 1'b1);
    repeat (7) step();
    reset_cycles(3);
    step();

    // Zero duration
`ifdef TONE_GEN_LOOP_EN
    send(0, 2, 0, 1'b1);
    repeat (1100) step();
    do_stop(0);
    repeat (3) step();
`else
    send(0, 2, 0, 1'b1);
    repeat (3) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
